// File: rtl/led_pwm_bank.sv
// led_pwm_bank: multi-channel LED PWM driver with per-channel duty and mode.
//
// A shared prescaler produces PWM ticks. A shared DIM_BITS-wide frame counter
// is compared against each channel's effective duty. Configuration goes into
// per-channel shadow registers and is copied to the active registers only at
// a frame boundary, so a frame never carries a partial pulse.
//
// Optional feature macro: LED_PWM_BREATHE_EN
//   Defined:   breathe mode (mode 2) ramps brightness up and down.
//   Undefined: the breathe counter is absent and mode 2 acts as steady.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset, clears all state
//   en        in   [CHANNELS]  per-channel level enable (not frame-synchronised)
//   cfg_we    in   single-cycle configuration write strobe
//   cfg_ch    in   [CH_W]      target channel; values >= CHANNELS are ignored
//   cfg_duty  in   [DIM_BITS]  duty value
//   cfg_mode  in   [2]         0 steady, 1 blink, 2 breathe, 3 off
//   led       out  [CHANNELS]  registered LED drive, active-high
module led_pwm_bank #(
  parameter int CHANNELS     = 2,
  parameter int DIM_BITS     = 8,
  parameter int PRESCALE     = 12,
  parameter int BLINK_FRAMES = 3906,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIM_BITS-1:0] cfg_duty,
  input  logic [1:0]          cfg_mode,
  output logic [CHANNELS-1:0] led
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(PRESCALE - 1);
  localparam logic [BF_W-1:0]     BF_MAX   = BF_W'(BLINK_FRAMES - 1);
  localparam logic [DIM_BITS-1:0] DUTY_MAX = {DIM_BITS{1'b1}};

  localparam logic [1:0] MODE_STEADY  = 2'd0;
  localparam logic [1:0] MODE_BLINK   = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;
  localparam logic [1:0] MODE_OFF     = 2'd3;

  logic [PRE_W-1:0]    pre_cnt_r;
  logic [DIM_BITS-1:0] pwm_cnt_r;
  logic [BF_W-1:0]     blink_cnt_r;
  logic                blink_ph_r;
  logic                tick_s;
  logic                frame_end_s;

  logic [DIM_BITS-1:0] shd_duty_r [CHANNELS];
  logic [1:0]          shd_mode_r [CHANNELS];
  logic [DIM_BITS-1:0] act_duty_r [CHANNELS];
  logic [1:0]          act_mode_r [CHANNELS];
  logic [DIM_BITS-1:0] eff_duty_s [CHANNELS];
  logic [CHANNELS-1:0] led_r;

  assign tick_s      = (pre_cnt_r == PRE_MAX);
  assign frame_end_s = tick_s && (pwm_cnt_r == DUTY_MAX);

  // Prescaler: one tick every PRESCALE clk cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_r <= {PRE_W{1'b0}};
    end else if (tick_s) begin
      pre_cnt_r <= {PRE_W{1'b0}};
    end else begin
      pre_cnt_r <= pre_cnt_r + PRE_W'(1'b1);
    end
  end

  // PWM frame counter: advances on each tick and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_r <= {DIM_BITS{1'b0}};
    end else if (tick_s) begin
      pwm_cnt_r <= pwm_cnt_r + DIM_BITS'(1'b1);
    end
  end

  // Blink timebase: phase flips every BLINK_FRAMES frames, starting in the on phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_r <= {BF_W{1'b0}};
      blink_ph_r  <= 1'b1;
    end else if (frame_end_s) begin
      if (blink_cnt_r == BF_MAX) begin
        blink_cnt_r <= {BF_W{1'b0}};
        blink_ph_r  <= ~blink_ph_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BF_W'(1'b1);
      end
    end
  end

`ifdef LED_PWM_BREATHE_EN
  localparam logic [DIM_BITS-1:0] BRTH_TOP = DUTY_MAX - DIM_BITS'(1'b1);
  localparam logic [DIM_BITS-1:0] BRTH_ONE = DIM_BITS'(1'b1);

  logic [DIM_BITS-1:0] brth_r;
  logic                brth_up_r;

  // Breathe level: triangle 0 -> max -> 0, direction flips on the frame that reaches an end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brth_r    <= {DIM_BITS{1'b0}};
      brth_up_r <= 1'b1;
    end else if (frame_end_s) begin
      if (brth_up_r) begin
        brth_r <= brth_r + DIM_BITS'(1'b1);
        if (brth_r == BRTH_TOP) begin
          brth_up_r <= 1'b0;
        end
      end else begin
        brth_r <= brth_r - DIM_BITS'(1'b1);
        if (brth_r == BRTH_ONE) begin
          brth_up_r <= 1'b1;
        end
      end
    end
  end
`endif

  // Shadow registers: written by the config port; out-of-range channels match no slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shd_duty_r[i] <= {DIM_BITS{1'b0}};
        shd_mode_r[i] <= MODE_STEADY;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_we && (cfg_ch == CH_W'(i))) begin
          shd_duty_r[i] <= cfg_duty;
          shd_mode_r[i] <= cfg_mode;
        end
      end
    end
  end

  // Active registers: copied from the shadows at frame end. A write in the same
  // cycle lands in the shadow only, so it waits for the following frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        act_duty_r[i] <= {DIM_BITS{1'b0}};
        act_mode_r[i] <= MODE_STEADY;
      end
    end else if (frame_end_s) begin
      for (int i = 0; i < CHANNELS; i++) begin
        act_duty_r[i] <= shd_duty_r[i];
        act_mode_r[i] <= shd_mode_r[i];
      end
    end
  end

  // Effective duty per channel from its active mode.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      eff_duty_s[i] = {DIM_BITS{1'b0}};
      case (act_mode_r[i])
        MODE_STEADY: eff_duty_s[i] = act_duty_r[i];
        MODE_BLINK: begin
          if (blink_ph_r) begin
            eff_duty_s[i] = act_duty_r[i];
          end else begin
            eff_duty_s[i] = {DIM_BITS{1'b0}};
          end
        end
`ifdef LED_PWM_BREATHE_EN
        MODE_BREATHE: eff_duty_s[i] = (act_duty_r[i] < brth_r) ? act_duty_r[i] : brth_r;
`else
        MODE_BREATHE: eff_duty_s[i] = act_duty_r[i];
`endif
        MODE_OFF:    eff_duty_s[i] = {DIM_BITS{1'b0}};
        default:     eff_duty_s[i] = {DIM_BITS{1'b0}};
      endcase
    end
  end

  // LED output stage: compare registered once, gated by the raw enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r <= {CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        led_r[i] <= en[i] && (eff_duty_s[i] > pwm_cnt_r);
      end
    end
  end

  assign led = led_r;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed testbench for led_pwm_bank with a 16-tick frame and one tick per clk.
// Three channels are instantiated so that cfg_ch can address a slot that does
// not exist. Frames are tracked by counting clock edges from reset release:
// led sampled after edge 16*f+k (k = 1..16) belongs to output frame f.
module tb_led_pwm_bank;
  localparam int CHN   = 3;
  localparam int DIM   = 4;
  localparam int PRE   = 1;
  localparam int BF    = 2;
  localparam int FRAME = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [CHN-1:0] en;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [DIM-1:0] cfg_duty;
  logic [1:0]     cfg_mode;
  logic [CHN-1:0] led;

  int n_chk  = 0;
  int n_pass = 0;
  int ecnt   = 0;
  int h0, h1, h2, fi;

  always #5 clk = ~clk;

  led_pwm_bank #(
    .CHANNELS(CHN), .DIM_BITS(DIM), .PRESCALE(PRE), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_duty(cfg_duty), .cfg_mode(cfg_mode), .led(led)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // one clock edge; returns just after the following falling edge
  task automatic step();
    @(posedge clk);
    ecnt++;
    @(negedge clk);
  endtask

  // run one aligned output frame, optionally writing config at offset wr_at
  task automatic frame(input int wr_at, input logic [1:0] ch, input logic [3:0] duty,
                       input logic [1:0] mode, output int c0, output int c1, output int c2);
    while (ecnt % FRAME != 0) step();
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == wr_at) begin
        cfg_ch = ch; cfg_duty = duty; cfg_mode = mode; cfg_we = 1'b1;
      end
      step();
      cfg_we = 1'b0;
      if (led[0]) c0++;
      if (led[1]) c1++;
      if (led[2]) c2++;
    end
  endtask

  function automatic int blink_exp(input int f, input int duty);
    return (((f / BF) % 2) == 0) ? duty : 0;
  endfunction

  function automatic int brth_exp(input int f);
    int m;
    m = f % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  initial begin
    reset = 1'b1; en = 3'b000; cfg_we = 1'b0;
    cfg_ch = 2'd0; cfg_duty = 4'd0; cfg_mode = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_led", int'(led), 0);
    #1 reset = 1'b0;
    ecnt = 0;

    // reset state: nothing lights
    en = 3'b001;
    frame(-1, 2'd0, 4'd0, 2'd0, h0, h1, h2);
    chk("rst_duty0_ch0", h0, 0);
    chk("rst_duty0_ch1", h1, 0);

    // steady duty 5 on ch0, ch1 disabled
    frame(3, 2'd0, 4'd5, 2'd0, h0, h1, h2);
    chk("pre_load", h0, 0);
    frame(-1, 2'd0, 4'd0, 2'd0, h0, h1, h2);
    chk("duty5", h0, 5);
    chk("ch1_idle", h1, 0);

    // mid-frame change 5 -> 12
    frame(3, 2'd0, 4'd12, 2'd0, h0, h1, h2);
    chk("midframe_keep", h0, 5);
    frame(-1, 2'd0, 4'd0, 2'd0, h0, h1, h2);
    chk("duty12", h0, 12);

    // write landing on the frame_end cycle is deferred one frame
    frame(15, 2'd0, 4'd3, 2'd0, h0, h1, h2);
    chk("fe_write_same", h0, 12);
    frame(-1, 2'd0, 4'd0, 2'd0, h0, h1, h2);
    chk("fe_write_defer", h0, 12);
    frame(-1, 2'd0, 4'd0, 2'd0, h0, h1, h2);
    chk("fe_write_apply", h0, 3);

    // out-of-range channel write changes nothing
    en = 3'b111;
    frame(2, 2'd3, 4'd15, 2'd0, h0, h1, h2);
    frame(-1, 2'd0, 4'd0, 2'd0, h0, h1, h2);
    chk("oor_ch0", h0, 3);
    chk("oor_ch1", h1, 0);
    chk("oor_ch2", h2, 0);

    // blink on ch1: 2 frames on, 2 frames off, on phase from reset
    frame(3, 2'd1, 4'd15, 2'd1, h0, h1, h2);
    for (int k = 0; k < 4; k++) begin
      fi = ecnt / FRAME;
      frame(-1, 2'd0, 4'd0, 2'd0, h0, h1, h2);
      chk($sformatf("blink_f%0d", fi), h1, blink_exp(fi, 15));
    end

    // breathe on ch0
    frame(3, 2'd0, 4'd15, 2'd2, h0, h1, h2);
    for (int k = 0; k < 32; k++) begin
      fi = ecnt / FRAME;
      frame(-1, 2'd0, 4'd0, 2'd0, h0, h1, h2);
`ifdef LED_PWM_BREATHE_EN
      chk($sformatf("breathe_f%0d", fi), h0, brth_exp(fi));
`else
      chk($sformatf("breathe_f%0d", fi), h0, 15);
`endif
    end

    // mode off on ch1, then ch0 back to steady full duty
    frame(3, 2'd1, 4'd15, 2'd3, h0, h1, h2);
    frame(3, 2'd0, 4'd15, 2'd0, h0, h1, h2);
    chk("mode_off", h1, 0);
    frame(-1, 2'd0, 4'd0, 2'd0, h0, h1, h2);
    chk("duty15", h0, 15);

    // enable drop mid-pulse
    repeat (3) step();
    chk("en_pulse", int'(led[0]), 1);
    en = 3'b110;
    step();
    chk("en_drop", int'(led[0]), 0);
    en = 3'b111;
    step();
    chk("en_restore", int'(led[0]), 1);

    // reset mid-pulse, between edges
    #1 reset = 1'b1;
    #1 chk("rst_async", int'(led), 0);
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    ecnt = 0;
    frame(3, 2'd1, 4'd15, 2'd1, h0, h1, h2);
    chk("rst_clr_ch0", h0, 0);
    chk("rst_clr_ch1", h1, 0);
    chk("rst_clr_ch2", h2, 0);
    frame(3, 2'd0, 4'd5, 2'd0, h0, h1, h2);
    chk("rst_blink_on", h1, 15);
    chk("rst_duty_kept0", h0, 0);
    frame(-1, 2'd0, 4'd0, 2'd0, h0, h1, h2);
    chk("rst_pwm_align", h0, 5);
    chk("rst_blink_off", h1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
